// File: rtl/decode_issue_pkg.sv
// Shared types and constants for the decode-to-ALU issue buffer.
// Optional build macro: DECODE_ISSUE_BUF_PERF_EN (adds performance counters to decode_issue_buffer).
package decode_issue_pkg;

   localparam int ISSUE_DATA_W     = 32;
   localparam int ISSUE_REG_ADDR_W = 5;
   localparam int ISSUE_CTRL_W     = 16;
   localparam int ISSUE_DEPTH      = 4;

   // Position of MEM_R_EN inside the packed control bundle; a set bit marks a load
   localparam int CTRL_MEM_R_EN_BIT = 0;

   // One fully decoded instruction as it sits in the issue buffer
   typedef struct packed {
      logic [ISSUE_DATA_W-1:0]     pc;
      logic [ISSUE_DATA_W-1:0]     rega_data;
      logic [ISSUE_DATA_W-1:0]     regb_data;
      logic [ISSUE_DATA_W-1:0]     imm;
      logic [ISSUE_CTRL_W-1:0]     ctrl;
      logic [ISSUE_REG_ADDR_W-1:0] rega;
      logic [ISSUE_REG_ADDR_W-1:0] regb;
      logic [ISSUE_REG_ADDR_W-1:0] regd;
      logic                        uses_rega;
      logic                        uses_regb;
   } issue_entry_t;

endpackage

// File: rtl/decode_issue_hazard.sv
// Load-use tracker: remembers the destination of the load that issued last cycle and
// raises a one-cycle bubble when the buffer head reads that register.
module decode_issue_hazard
   import decode_issue_pkg::*;
#(
   parameter int REG_ADDR_W = ISSUE_REG_ADDR_W
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_flush,
   input  logic                  i_freeze,
   input  logic                  i_pop,
   input  logic                  i_popIsLoad,
   input  logic [REG_ADDR_W-1:0] i_popRegd,
   input  logic [REG_ADDR_W-1:0] i_headRega,
   input  logic [REG_ADDR_W-1:0] i_headRegb,
   input  logic                  i_headUsesRega,
   input  logic                  i_headUsesRegb,
   output logic                  o_bubble
);

   logic                  r_trkValid;
   logic [REG_ADDR_W-1:0] r_trkRegd;

   // Capture the issuing instruction's load destination; register 0 is never a hazard.
   // A data-cache freeze holds the tracker so the bubble still lands after the stall,
   // and any other cycle without an issue forgets it so the bubble lasts one cycle only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_trkValid <= 1'b0;
         r_trkRegd  <= '0;
      end else if (i_flush) begin
         r_trkValid <= 1'b0;
      end else if (!i_freeze) begin
         if (i_pop) begin
            r_trkValid <= i_popIsLoad & (i_popRegd != '0);
            r_trkRegd  <= i_popRegd;
         end else begin
            r_trkValid <= 1'b0;
         end
      end
   end

   // Compare the tracked destination against whichever head sources are actually read
   always_comb begin
      o_bubble = r_trkValid &
                 ((i_headUsesRega & (i_headRega == r_trkRegd)) |
                  (i_headUsesRegb & (i_headRegb == r_trkRegd)));
   end

endmodule

// File: rtl/decode_issue_buffer.sv
// In-order issue FIFO between decode and the ALU with valid/ready handshakes, flush,
// cache-stall blocking and automatic load-use bubble insertion.
// Optional build macro: DECODE_ISSUE_BUF_PERF_EN adds bubble_cnt, stall_cnt and full_cnt.
module decode_issue_buffer
   import decode_issue_pkg::*;
#(
   parameter int DATA_W     = ISSUE_DATA_W,
   parameter int REG_ADDR_W = ISSUE_REG_ADDR_W,
   parameter int CTRL_W     = ISSUE_CTRL_W,
   parameter int DEPTH      = ISSUE_DEPTH
)(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         block_pipe_instr_cache,
   input  logic                         block_pipe_data_cache,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_W-1:0]            in_pc,
   input  logic [DATA_W-1:0]            in_rega_data,
   input  logic [DATA_W-1:0]            in_regb_data,
   input  logic [DATA_W-1:0]            in_imm,
   input  logic [CTRL_W-1:0]            in_ctrl,
   input  logic [REG_ADDR_W-1:0]        in_rega,
   input  logic [REG_ADDR_W-1:0]        in_regb,
   input  logic [REG_ADDR_W-1:0]        in_regd,
   input  logic                         in_uses_rega,
   input  logic                         in_uses_regb,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_W-1:0]            out_pc,
   output logic [DATA_W-1:0]            out_rega_data,
   output logic [DATA_W-1:0]            out_regb_data,
   output logic [DATA_W-1:0]            out_imm,
   output logic [CTRL_W-1:0]            out_ctrl,
   output logic [REG_ADDR_W-1:0]        out_rega,
   output logic [REG_ADDR_W-1:0]        out_regb,
   output logic [REG_ADDR_W-1:0]        out_regd,
   output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef DECODE_ISSUE_BUF_PERF_EN
   ,
   output logic [31:0]                  bubble_cnt,
   output logic [31:0]                  stall_cnt,
   output logic [31:0]                  full_cnt
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   issue_entry_t     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0] r_count;

   issue_entry_t     w_newEntry;
   issue_entry_t     w_head;
   logic             w_empty;
   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic             w_bubble;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_head  = r_mem[r_rdPtr];
   assign count   = r_count;

   // Handshakes: in_ready never looks at out_ready, so a full buffer refuses input even
   // while it is popping; out_valid is held low for a load-use bubble or a data-cache stall
   always_comb begin
      in_ready  = !w_full & !flush & !block_pipe_instr_cache;
      out_valid = !w_empty & !w_bubble & !block_pipe_data_cache;
      w_push    = in_valid & in_ready;
      w_pop     = out_valid & out_ready;
   end

   // Pack the decode-side inputs into one storage entry
   always_comb begin
      w_newEntry.pc        = in_pc;
      w_newEntry.rega_data = in_rega_data;
      w_newEntry.regb_data = in_regb_data;
      w_newEntry.imm       = in_imm;
      w_newEntry.ctrl      = in_ctrl;
      w_newEntry.rega      = in_rega;
      w_newEntry.regb      = in_regb;
      w_newEntry.regd      = in_regd;
      w_newEntry.uses_rega = in_uses_rega;
      w_newEntry.uses_regb = in_uses_regb;
   end

   // Head payload is read straight from storage but forced to zero when the buffer is
   // empty, so stale entries never leak out (including right after an async reset)
   always_comb begin
      out_pc        = '0;
      out_rega_data = '0;
      out_regb_data = '0;
      out_imm       = '0;
      out_ctrl      = '0;
      out_rega      = '0;
      out_regb      = '0;
      out_regd      = '0;
      if (!w_empty) begin
         out_pc        = w_head.pc;
         out_rega_data = w_head.rega_data;
         out_regb_data = w_head.regb_data;
         out_imm       = w_head.imm;
         out_ctrl      = w_head.ctrl;
         out_rega      = w_head.rega;
         out_regb      = w_head.regb;
         out_regd      = w_head.regd;
      end
   end

   // Entry storage needs no reset: occupancy alone decides what is visible
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= w_newEntry;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two; the handshakes guarantee
   // the count never over- or underflows, and flush empties everything at once
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   decode_issue_hazard #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_hazard (
      .clk            (clk),
      .reset          (reset),
      .i_flush        (flush),
      .i_freeze       (block_pipe_data_cache),
      .i_pop          (w_pop),
      .i_popIsLoad    (w_head.ctrl[CTRL_MEM_R_EN_BIT]),
      .i_popRegd      (w_head.regd),
      .i_headRega     (w_head.rega),
      .i_headRegb     (w_head.regb),
      .i_headUsesRega (w_head.uses_rega),
      .i_headUsesRegb (w_head.uses_regb),
      .o_bubble       (w_bubble)
   );

`ifdef DECODE_ISSUE_BUF_PERF_EN
   logic w_bubbleCycle;
   assign w_bubbleCycle = !w_empty & w_bubble & !block_pipe_data_cache;

   // Free-running event counters; they survive flush and only reset clears them
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bubble_cnt <= '0;
         stall_cnt  <= '0;
         full_cnt   <= '0;
      end else begin
         if (w_bubbleCycle) begin
            bubble_cnt <= bubble_cnt + 32'd1;
         end
         if (!w_empty && block_pipe_data_cache) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (w_full && in_valid) begin
            full_cnt <= full_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_decode_issue_buffer.sv
// Self-checking bench for decode_issue_buffer: directed scenarios followed by random
// traffic, all compared every cycle against a queue-based reference model.
// Optional build macro: DECODE_ISSUE_BUF_PERF_EN also checks the performance counters.
module tb_decode_issue_buffer;

   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;
   localparam int CTRL_W     = 16;
   localparam int DEPTH      = 4;
   localparam int CNT_W      = $clog2(DEPTH+1);

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  flush;
   logic                  block_pipe_instr_cache;
   logic                  block_pipe_data_cache;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_W-1:0]     in_pc;
   logic [DATA_W-1:0]     in_rega_data;
   logic [DATA_W-1:0]     in_regb_data;
   logic [DATA_W-1:0]     in_imm;
   logic [CTRL_W-1:0]     in_ctrl;
   logic [REG_ADDR_W-1:0] in_rega;
   logic [REG_ADDR_W-1:0] in_regb;
   logic [REG_ADDR_W-1:0] in_regd;
   logic                  in_uses_rega;
   logic                  in_uses_regb;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_W-1:0]     out_pc;
   logic [DATA_W-1:0]     out_rega_data;
   logic [DATA_W-1:0]     out_regb_data;
   logic [DATA_W-1:0]     out_imm;
   logic [CTRL_W-1:0]     out_ctrl;
   logic [REG_ADDR_W-1:0] out_rega;
   logic [REG_ADDR_W-1:0] out_regb;
   logic [REG_ADDR_W-1:0] out_regd;
   logic [CNT_W-1:0]      count;
`ifdef DECODE_ISSUE_BUF_PERF_EN
   logic [31:0]           bubble_cnt;
   logic [31:0]           stall_cnt;
   logic [31:0]           full_cnt;
`endif

   decode_issue_buffer #(
      .DATA_W     (DATA_W),
      .REG_ADDR_W (REG_ADDR_W),
      .CTRL_W     (CTRL_W),
      .DEPTH      (DEPTH)
   ) dut (
      .clk                    (clk),
      .reset                  (reset),
      .flush                  (flush),
      .block_pipe_instr_cache (block_pipe_instr_cache),
      .block_pipe_data_cache  (block_pipe_data_cache),
      .in_valid               (in_valid),
      .in_ready               (in_ready),
      .in_pc                  (in_pc),
      .in_rega_data           (in_rega_data),
      .in_regb_data           (in_regb_data),
      .in_imm                 (in_imm),
      .in_ctrl                (in_ctrl),
      .in_rega                (in_rega),
      .in_regb                (in_regb),
      .in_regd                (in_regd),
      .in_uses_rega           (in_uses_rega),
      .in_uses_regb           (in_uses_regb),
      .out_valid              (out_valid),
      .out_ready              (out_ready),
      .out_pc                 (out_pc),
      .out_rega_data          (out_rega_data),
      .out_regb_data          (out_regb_data),
      .out_imm                (out_imm),
      .out_ctrl               (out_ctrl),
      .out_rega               (out_rega),
      .out_regb               (out_regb),
      .out_regd               (out_regd),
      .count                  (count)
`ifdef DECODE_ISSUE_BUF_PERF_EN
      ,
      .bubble_cnt             (bubble_cnt),
      .stall_cnt              (stall_cnt),
      .full_cnt               (full_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] aData;
      logic [31:0] bData;
      logic [31:0] imm;
      logic [15:0] ctrl;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [4:0]  rd;
      logic        ua;
      logic        ub;
   } tbEntry_t;

   tbEntry_t    modelQ[$];
   bit          trkValid = 1'b0;
   logic [4:0]  trkRegd  = '0;
   int          checks   = 0;
   int          errors   = 0;
   bit          expInReady;
   bit          expOutValid;
   bit          expBubble;
   bit          doPush;
   bit          doPop;
   tbEntry_t    offered;
   logic [31:0] mBubble = '0;
   logic [31:0] mStall  = '0;
   logic [31:0] mFull   = '0;

   // One comparison: count it, and report any difference
   task automatic checkVal(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // A head instruction stalls when it reads the register the last issued load writes
   function automatic bit hazardFor(input tbEntry_t e);
      return trkValid && ((e.ua && e.ra == trkRegd) || (e.ub && e.rb == trkRegd));
   endfunction

   // Offer one decoded instruction with random operand data
   task automatic setEntry(input logic [31:0] pc, input logic [15:0] ctrl, input logic [4:0] ra,
                           input logic [4:0] rb, input logic [4:0] rd, input logic ua, input logic ub);
      in_valid     = 1'b1;
      in_pc        = pc;
      in_ctrl      = ctrl;
      in_rega      = ra;
      in_regb      = rb;
      in_regd      = rd;
      in_uses_rega = ua;
      in_uses_regb = ub;
      in_rega_data = $urandom;
      in_regb_data = $urandom;
      in_imm       = $urandom;
   endtask

   // Predict all outputs from the model and compare; also decide this cycle's handshakes
   task automatic checkOutput();
      tbEntry_t h;
      int       n;
      n           = modelQ.size();
      expInReady  = (n < DEPTH) && !flush && !block_pipe_instr_cache;
      expBubble   = (n != 0) && hazardFor(modelQ[0]);
      expOutValid = (n != 0) && !expBubble && !block_pipe_data_cache;
      h = '{default: '0};
      if (n != 0) h = modelQ[0];
      checkVal("in_ready", 64'(in_ready), 64'(expInReady));
      checkVal("out_valid", 64'(out_valid), 64'(expOutValid));
      checkVal("count", 64'(count), 64'(n));
      checkVal("out_pc", 64'(out_pc), 64'(h.pc));
      checkVal("out_rega_data", 64'(out_rega_data), 64'(h.aData));
      checkVal("out_regb_data", 64'(out_regb_data), 64'(h.bData));
      checkVal("out_imm", 64'(out_imm), 64'(h.imm));
      checkVal("out_ctrl", 64'(out_ctrl), 64'(h.ctrl));
      checkVal("out_regs", {49'd0, out_rega, out_regb, out_regd}, {49'd0, h.ra, h.rb, h.rd});
`ifdef DECODE_ISSUE_BUF_PERF_EN
      checkVal("bubble_cnt", 64'(bubble_cnt), 64'(mBubble));
      checkVal("stall_cnt", 64'(stall_cnt), 64'(mStall));
      checkVal("full_cnt", 64'(full_cnt), 64'(mFull));
`endif
      doPush  = in_valid && expInReady;
      doPop   = expOutValid && out_ready;
      offered = '{in_pc, in_rega_data, in_regb_data, in_imm, in_ctrl,
                  in_rega, in_regb, in_regd, in_uses_rega, in_uses_regb};
   endtask

   // Advance the reference model across one clock edge
   task automatic updateModel();
      tbEntry_t e;
      int       n;
      n = modelQ.size();
      if (n != 0 && expBubble && !block_pipe_data_cache) mBubble = mBubble + 32'd1;
      if (n != 0 && block_pipe_data_cache) mStall = mStall + 32'd1;
      if (n == DEPTH && in_valid) mFull = mFull + 32'd1;
      if (flush) begin
         modelQ.delete();
         trkValid = 1'b0;
      end else begin
         if (doPop) begin
            e        = modelQ.pop_front();
            trkValid = e.ctrl[0] && (e.rd != 5'd0);
            trkRegd  = e.rd;
         end else if (!block_pipe_data_cache) begin
            trkValid = 1'b0;
         end
         if (doPush) modelQ.push_back(offered);
      end
   endtask

   // One cycle: inputs were set at the falling edge, check just after, then clock
   task automatic applyStimulus();
      #1;
      checkOutput();
      @(posedge clk);
      updateModel();
      @(negedge clk);
   endtask

   task automatic modelReset();
      modelQ.delete();
      trkValid = 1'b0;
      mBubble  = '0;
      mStall   = '0;
      mFull    = '0;
   endtask

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      block_pipe_instr_cache = 1'b0;
      block_pipe_data_cache  = 1'b0;
      out_ready = 1'b0;
      setEntry(32'h0, 16'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2;
      checkOutput();
      @(negedge clk);
      reset = 1'b0;

      $display("[TB] fill to full, refuse a fifth entry, drain in order");
      for (int i = 0; i < 4; i++) begin
         setEntry(32'h10 + 32'(4*i), 16'h0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
         applyStimulus();
      end
      setEntry(32'h20, 16'h0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
      checkVal("full_count", 64'(count), 64'd4);
      applyStimulus();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checkVal("drain_pc", 64'(out_pc), 64'(32'h10 + 32'(4*i)));
         applyStimulus();
      end
      for (int i = 0; i < 6; i++) begin
         setEntry(32'h30 + 32'(4*i), 16'h0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
         applyStimulus();
      end
      in_valid = 1'b0;
      repeat (3) applyStimulus();

      $display("[TB] load-use bubble, then register 0 load");
      setEntry(32'h100, 16'h0001, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0);
      applyStimulus();
      setEntry(32'h104, 16'h0000, 5'd5, 5'd0, 5'd7, 1'b1, 1'b0);
      applyStimulus();
      in_valid = 1'b0;
      #1;
      checkVal("bubble_valid", 64'(out_valid), 64'd0);
      #(-0);
      repeat (3) applyStimulus();
      setEntry(32'h110, 16'h0001, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      applyStimulus();
      setEntry(32'h114, 16'h0000, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
      applyStimulus();
      in_valid = 1'b0;
      repeat (3) applyStimulus();

      $display("[TB] data-cache block after a load");
      setEntry(32'h200, 16'h0001, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0);
      applyStimulus();
      setEntry(32'h204, 16'h0000, 5'd1, 5'd6, 5'd7, 1'b0, 1'b1);
      applyStimulus();
      in_valid = 1'b0;
      block_pipe_data_cache = 1'b1;
      repeat (3) applyStimulus();
      block_pipe_data_cache = 1'b0;
      repeat (3) applyStimulus();

      $display("[TB] flush while full with an offered entry");
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         setEntry(32'h300 + 32'(4*i), 16'h0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
         applyStimulus();
      end
      setEntry(32'h399, 16'h0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
      flush = 1'b1;
      applyStimulus();
      flush = 1'b0;
      setEntry(32'h400, 16'h0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
      applyStimulus();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checkVal("flush_next_pc", 64'(out_pc), 64'h400);
      applyStimulus();

      $display("[TB] both cache blocks high");
      out_ready = 1'b0;
      setEntry(32'h500, 16'h0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
      applyStimulus();
      out_ready = 1'b1;
      block_pipe_instr_cache = 1'b1;
      block_pipe_data_cache  = 1'b1;
      repeat (2) applyStimulus();
      block_pipe_instr_cache = 1'b0;
      block_pipe_data_cache  = 1'b0;
      in_valid = 1'b0;
      repeat (2) applyStimulus();

      $display("[TB] async reset with three entries queued");
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         setEntry(32'h600 + 32'(4*i), 16'h0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
         applyStimulus();
      end
      in_valid = 1'b0;
      #2;
      reset = 1'b1;
      modelReset();
      #1;
      checkOutput();
      checkVal("reset_pc_zero", 64'(out_pc), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      $display("[TB] random traffic");
      for (int c = 0; c < 600; c++) begin
         setEntry($urandom, 16'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         block_pipe_instr_cache = ($urandom_range(0, 9) == 0);
         block_pipe_data_cache  = ($urandom_range(0, 7) == 0);
         flush = ($urandom_range(0, 49) == 0);
         applyStimulus();
      end
      flush = 1'b0;
      block_pipe_instr_cache = 1'b0;
      block_pipe_data_cache  = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (8) applyStimulus();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
